mbinit_param_negotiator: RTL and testbench



---
 rtl/mbinit_param_negotiator.sv | 144 ++++++++++++++
 tb/tb_mbinit_param_negotiator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mbinit_param_negotiator.sv
// mbinit_param_negotiator: MBINIT.PARAM capability advertise/capture/resolve FSM.
// Optional remote voltage-swing compare enabled by defining VSWING_CHECK_EN.
module mbinit_param_negotiator #(
  parameter int         RATE_W          = 3,
  parameter int         MAX_RATE_CODE   = 5,
  parameter int         LOCAL_MAX_RATE  = 2,
  parameter logic [1:0] LOCAL_CLK_MODE  = 2'b00,
  parameter logic [1:0] LOCAL_CLK_PHASE = 2'b01,
  parameter int         VSWING_W        = 5,
  parameter int         TIMEOUT_CYC     = 1024
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [VSWING_W-1:0] i_voltage_swing,
  input  logic                i_remote_valid,
  input  logic [RATE_W-1:0]   i_remote_rate,
  input  logic [1:0]          i_remote_clk_mode,
  input  logic [1:0]          i_remote_clk_phase,
  input  logic [VSWING_W-1:0] i_remote_vswing,
  output logic                o_local_valid,
  output logic [RATE_W-1:0]   o_local_rate,
  output logic [1:0]          o_local_clk_mode,
  output logic [1:0]          o_local_clk_phase,
  output logic [VSWING_W-1:0] o_local_vswing,
  output logic [RATE_W-1:0]   o_neg_rate,
  output logic [1:0]          o_neg_clk_mode,
  output logic [1:0]          o_neg_clk_phase,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [1:0]          o_err_code
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [RATE_W-1:0] L_MAX_RATE = RATE_W'(MAX_RATE_CODE);
  localparam logic [RATE_W-1:0] L_LOC_RATE = RATE_W'(LOCAL_MAX_RATE);
  localparam logic [CW-1:0]     L_TERM     = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, ADVERTISE, WAIT_REMOTE, RESOLVE, DONE, ERROR} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [RATE_W-1:0]   r_rem_rate;
  logic [1:0]          r_rem_clk_mode;
  logic [1:0]          r_rem_clk_phase;
  logic [VSWING_W-1:0] r_rem_vswing;
  logic                w_bad_rate;
  logic                w_clk_mis;
  logic                w_vs_mis;
  logic [1:0]          w_err_code;
  logic [RATE_W-1:0]   w_min_rate;

  assign w_bad_rate = r_rem_rate > L_MAX_RATE;
  assign w_clk_mis  = (r_rem_clk_mode != LOCAL_CLK_MODE) || (r_rem_clk_phase != LOCAL_CLK_PHASE);
`ifdef VSWING_CHECK_EN
  assign w_vs_mis   = r_rem_vswing != o_local_vswing;
`else
  // remote swing is still captured; folding it in keeps it referenced while never flagging
  assign w_vs_mis   = &{1'b0, r_rem_vswing};
`endif
  assign w_err_code = w_bad_rate ? 2'd2 : w_clk_mis ? 2'd1 : 2'd3;
  assign w_min_rate = (r_rem_rate < L_LOC_RATE) ? r_rem_rate : L_LOC_RATE;
  assign o_busy     = (r_state == ADVERTISE) || (r_state == WAIT_REMOTE) || (r_state == RESOLVE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_rem_rate        <= '0;
      r_rem_clk_mode    <= '0;
      r_rem_clk_phase   <= '0;
      r_rem_vswing      <= '0;
      o_local_valid     <= 1'b0;
      o_local_rate      <= '0;
      o_local_clk_mode  <= '0;
      o_local_clk_phase <= '0;
      o_local_vswing    <= '0;
      o_neg_rate        <= '0;
      o_neg_clk_mode    <= '0;
      o_neg_clk_phase   <= '0;
      o_done            <= 1'b0;
      o_error           <= 1'b0;
      o_err_code        <= '0;
    end else if (i_abort) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      o_local_valid <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: if (i_start) begin
          r_state         <= ADVERTISE;
          r_cnt           <= '0;
          o_done          <= 1'b0;
          o_error         <= 1'b0;
          o_err_code      <= '0;
          o_neg_rate      <= '0;
          o_neg_clk_mode  <= '0;
          o_neg_clk_phase <= '0;
        end
        ADVERTISE: begin
          r_state           <= WAIT_REMOTE;
          o_local_vswing    <= i_voltage_swing;
          o_local_rate      <= L_LOC_RATE;
          o_local_clk_mode  <= LOCAL_CLK_MODE;
          o_local_clk_phase <= LOCAL_CLK_PHASE;
          o_local_valid     <= 1'b1;
        end
        WAIT_REMOTE: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_remote_valid) begin
            r_state         <= RESOLVE;
            r_rem_rate      <= i_remote_rate;
            r_rem_clk_mode  <= i_remote_clk_mode;
            r_rem_clk_phase <= i_remote_clk_phase;
            r_rem_vswing    <= i_remote_vswing;
          end else if (r_cnt == L_TERM) begin
            r_state       <= ERROR;
            o_local_valid <= 1'b0;
            o_error       <= 1'b1;
            o_err_code    <= 2'd0;
          end
        end
        RESOLVE: begin
          o_local_valid <= 1'b0;
          if (w_bad_rate || w_clk_mis || w_vs_mis) begin
            r_state    <= ERROR;
            o_error    <= 1'b1;
            o_err_code <= w_err_code;
          end else begin
            r_state         <= DONE;
            o_done          <= 1'b1;
            o_neg_rate      <= w_min_rate;
            o_neg_clk_mode  <= LOCAL_CLK_MODE;
            o_neg_clk_phase <= LOCAL_CLK_PHASE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbinit_param_negotiator.sv
// tb_mbinit_param_negotiator: directed-vector bench, TIMEOUT_CYC=8; honours VSWING_CHECK_EN.
module tb_mbinit_param_negotiator;
  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [4:0] i_voltage_swing = '0;
  logic       i_remote_valid = 1'b0;
  logic [2:0] i_remote_rate = '0;
  logic [1:0] i_remote_clk_mode = '0;
  logic [1:0] i_remote_clk_phase = '0;
  logic [4:0] i_remote_vswing = '0;
  logic       o_local_valid;
  logic [2:0] o_local_rate;
  logic [1:0] o_local_clk_mode;
  logic [1:0] o_local_clk_phase;
  logic [4:0] o_local_vswing;
  logic [2:0] o_neg_rate;
  logic [1:0] o_neg_clk_mode;
  logic [1:0] o_neg_clk_phase;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [1:0] o_err_code;
  logic [24:0] all_outs;
  int n_err = 0;
  int n_chk = 0;

  assign all_outs = {o_local_valid, o_local_rate, o_local_clk_mode, o_local_clk_phase, o_local_vswing,
                     o_neg_rate, o_neg_clk_mode, o_neg_clk_phase, o_busy, o_done, o_error, o_err_code};

  mbinit_param_negotiator #(.TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_voltage_swing(i_voltage_swing), .i_remote_valid(i_remote_valid),
    .i_remote_rate(i_remote_rate), .i_remote_clk_mode(i_remote_clk_mode),
    .i_remote_clk_phase(i_remote_clk_phase), .i_remote_vswing(i_remote_vswing),
    .o_local_valid(o_local_valid), .o_local_rate(o_local_rate),
    .o_local_clk_mode(o_local_clk_mode), .o_local_clk_phase(o_local_clk_phase),
    .o_local_vswing(o_local_vswing), .o_neg_rate(o_neg_rate),
    .o_neg_clk_mode(o_neg_clk_mode), .o_neg_clk_phase(o_neg_clk_phase),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // leaves the bench in cycle 2 (first WAIT_REMOTE cycle)
  task automatic start_neg(input logic [4:0] vs);
    i_voltage_swing = vs;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
  endtask

  // leaves the bench in cycle k+2, where the result is visible
  task automatic send_remote(input logic [2:0] r, input logic [1:0] m, input logic [1:0] p, input logic [4:0] v);
    i_remote_rate = r;
    i_remote_clk_mode = m;
    i_remote_clk_phase = p;
    i_remote_vswing = v;
    i_remote_valid = 1'b1;
    tick();
    i_remote_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++; if (all_outs !== 25'd0) begin n_err++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
    rst_n = 1'b1;
    tick();
    start_neg(5'h0A);
    n_chk++; if (o_local_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_lv got=%b exp=1", o_local_valid); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (all_outs !== 25'd0) begin n_err++; $display("FAIL midreset_outs got=%h exp=0", all_outs); end
    tick();
    rst_n = 1'b1;
    tick();
    i_voltage_swing = 5'h0A;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_chk++; if ({o_local_valid, o_busy} !== 2'b01) begin n_err++; $display("FAIL cyc1_lv_busy got=%b exp=01", {o_local_valid, o_busy}); end
    tick();
    n_chk++; if (o_local_valid !== 1'b1) begin n_err++; $display("FAIL cyc2_lv got=%b exp=1", o_local_valid); end
    n_chk++; if ({o_local_rate, o_local_clk_mode, o_local_clk_phase, o_local_vswing} !== {3'd2, 2'b00, 2'b01, 5'h0A})
      begin n_err++; $display("FAIL local_adv got=%h exp=%h", {o_local_rate, o_local_clk_mode, o_local_clk_phase, o_local_vswing}, {3'd2, 2'b00, 2'b01, 5'h0A}); end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
  endtask

  task automatic test_nominal();
    start_neg(5'h0A);
    tick();
    tick();
    tick();
    i_remote_rate = 3'd4; i_remote_clk_mode = 2'b00; i_remote_clk_phase = 2'b01; i_remote_vswing = 5'h0A;
    i_remote_valid = 1'b1;
    tick();
    i_remote_valid = 1'b0;
    n_chk++; if ({o_done, o_busy, o_local_valid} !== 3'b011) begin n_err++; $display("FAIL nom_cyc6 got=%b exp=011", {o_done, o_busy, o_local_valid}); end
    tick();
    n_chk++; if ({o_done, o_error, o_busy, o_local_valid} !== 4'b1000) begin n_err++; $display("FAIL nom_flags got=%b exp=1000", {o_done, o_error, o_busy, o_local_valid}); end
    n_chk++; if ({o_neg_rate, o_neg_clk_mode, o_neg_clk_phase} !== {3'd2, 2'b00, 2'b01})
      begin n_err++; $display("FAIL nom_neg got=%h exp=%h", {o_neg_rate, o_neg_clk_mode, o_neg_clk_phase}, {3'd2, 2'b00, 2'b01}); end
  endtask

  task automatic test_rate_min();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_chk++; if ({o_done, o_neg_rate, o_neg_clk_phase} !== 6'd0) begin n_err++; $display("FAIL restart_clear got=%h exp=0", {o_done, o_neg_rate, o_neg_clk_phase}); end
    tick();
    send_remote(3'd1, 2'b00, 2'b01, 5'h0A);
    n_chk++; if ({o_done, o_neg_rate} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL rate1 got=%h exp=%h", {o_done, o_neg_rate}, {1'b1, 3'd1}); end
    start_neg(5'h0A);
    send_remote(3'd5, 2'b00, 2'b01, 5'h0A);
    n_chk++; if ({o_done, o_neg_rate} !== {1'b1, 3'd2}) begin n_err++; $display("FAIL rate5 got=%h exp=%h", {o_done, o_neg_rate}, {1'b1, 3'd2}); end
    start_neg(5'h0A);
    send_remote(3'd6, 2'b00, 2'b01, 5'h0A);
    n_chk++; if ({o_done, o_error, o_err_code, o_neg_rate} !== {1'b0, 1'b1, 2'd2, 3'd0})
      begin n_err++; $display("FAIL rate6 got=%h exp=%h", {o_done, o_error, o_err_code, o_neg_rate}, {1'b0, 1'b1, 2'd2, 3'd0}); end
  endtask

  task automatic test_clk_mismatch();
    start_neg(5'h0A);
    send_remote(3'd3, 2'b00, 2'b10, 5'h0A);
    n_chk++; if ({o_error, o_err_code} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL phase_mis got=%b exp=101", {o_error, o_err_code}); end
    start_neg(5'h0A);
    send_remote(3'd7, 2'b00, 2'b10, 5'h0A);
    n_chk++; if ({o_error, o_err_code} !== {1'b1, 2'd2}) begin n_err++; $display("FAIL rate_prio got=%b exp=110", {o_error, o_err_code}); end
    start_neg(5'h0A);
    send_remote(3'd2, 2'b01, 2'b01, 5'h0A);
    n_chk++; if ({o_error, o_err_code, o_done} !== {1'b1, 2'd1, 1'b0}) begin n_err++; $display("FAIL mode_mis got=%b exp=1010", {o_error, o_err_code, o_done}); end
  endtask

  task automatic test_timeout();
    start_neg(5'h0A);
    repeat (7) tick();
    n_chk++; if ({o_error, o_local_valid} !== 2'b01) begin n_err++; $display("FAIL to_pre got=%b exp=01", {o_error, o_local_valid}); end
    tick();
    n_chk++; if ({o_error, o_err_code, o_local_valid, o_busy} !== 5'b10000) begin n_err++; $display("FAIL to_fire got=%b exp=10000", {o_error, o_err_code, o_local_valid, o_busy}); end
    start_neg(5'h0A);
    repeat (7) tick();
    i_remote_rate = 3'd4; i_remote_clk_mode = 2'b00; i_remote_clk_phase = 2'b01; i_remote_vswing = 5'h0A;
    i_remote_valid = 1'b1;
    tick();
    i_remote_valid = 1'b0;
    n_chk++; if ({o_error, o_busy} !== 2'b01) begin n_err++; $display("FAIL to_term_resolve got=%b exp=01", {o_error, o_busy}); end
    tick();
    n_chk++; if ({o_done, o_error, o_neg_rate} !== {1'b1, 1'b0, 3'd2}) begin n_err++; $display("FAIL to_term_done got=%h exp=%h", {o_done, o_error, o_neg_rate}, {1'b1, 1'b0, 3'd2}); end
  endtask

  task automatic test_abort();
    start_neg(5'h0A);
    tick();
    i_abort = 1'b1;
    i_start = 1'b1;
    i_voltage_swing = 5'h1F;
    tick();
    i_abort = 1'b0;
    i_start = 1'b0;
    n_chk++; if ({o_local_valid, o_busy, o_done, o_error} !== 4'b0000) begin n_err++; $display("FAIL abort_flags got=%b exp=0000", {o_local_valid, o_busy, o_done, o_error}); end
    n_chk++; if (o_local_vswing !== 5'h0A) begin n_err++; $display("FAIL abort_hold got=%h exp=0a", o_local_vswing); end
    tick();
    n_chk++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_prio got=%b exp=0", o_busy); end
    send_remote(3'd2, 2'b00, 2'b01, 5'h0A);
    n_chk++; if ({o_busy, o_done, o_error} !== 3'b000) begin n_err++; $display("FAIL idle_valid got=%b exp=000", {o_busy, o_done, o_error}); end
    start_neg(5'h0A);
    send_remote(3'd2, 2'b00, 2'b01, 5'h0A);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_chk++; if ({o_done, o_busy} !== 2'b00) begin n_err++; $display("FAIL abort_done got=%b exp=00", {o_done, o_busy}); end
  endtask

  task automatic test_vswing();
    start_neg(5'h0A);
    send_remote(3'd3, 2'b00, 2'b01, 5'h0B);
`ifdef VSWING_CHECK_EN
    n_chk++; if ({o_done, o_error, o_err_code} !== {1'b0, 1'b1, 2'd3}) begin n_err++; $display("FAIL vswing_mis got=%b exp=0111", {o_done, o_error, o_err_code}); end
`else
    n_chk++; if ({o_done, o_error, o_neg_rate} !== {1'b1, 1'b0, 3'd2}) begin n_err++; $display("FAIL vswing_ignored got=%h exp=%h", {o_done, o_error, o_neg_rate}, {1'b1, 1'b0, 3'd2}); end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rate_min();
    test_clk_mismatch();
    test_timeout();
    test_abort();
    test_vswing();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
